graph_coloring_solver: RTL

- Sequential backtracking search engine that produces a proper vertex colouring for a small graph.
- Generator-side counterpart to the combinational colouring checkers. Its `coloring` bus uses the same packing the checkers consume: vertex i occupies bits [2i+1:2i].
- Accepts an adjacency matrix and a colour budget, searches depth-first in vertex order, and returns either the first valid colouring found or a failure indication.

---
 rtl/gc_pkg.sv | 17 +
 rtl/gc_conflict_check.sv | 24 ++
 rtl/graph_coloring_solver.sv | 119 +++++++++++
 3 files changed

// File: rtl/gc_pkg.sv
// Shared types for the graph-colouring generator and checkers.
// Colour bus layout: vertex i occupies bits [i*COLOR_W +: COLOR_W].
package gc_pkg;
    localparam int GC_N_VERT  = 6;
    localparam int GC_COLOR_W = 2;

    typedef logic [GC_COLOR_W-1:0] color_t;

    typedef enum logic [1:0] {IDLE, CHECK, NEXT, DONE} state_t;

    function automatic logic [GC_N_VERT*GC_COLOR_W-1:0] pack_colors(input color_t c [GC_N_VERT]);
        logic [GC_N_VERT*GC_COLOR_W-1:0] p;
        p = '0;
        for (int i = 0; i < GC_N_VERT; i++) p[i*GC_COLOR_W +: GC_COLOR_W] = c[i];
        return p;
    endfunction
endpackage

// File: rtl/gc_conflict_check.sv
// Combinational check: does vertex v share a colour with any lower-numbered neighbour?
module gc_conflict_check #(
    parameter int N_VERT  = 6,
    parameter int COLOR_W = 2,
    parameter int VW      = $clog2(N_VERT)
) (
    input  logic [VW-1:0]              v,
    input  logic [N_VERT*COLOR_W-1:0]  coloring,
    input  logic [N_VERT*N_VERT-1:0]   adj,
    output logic                       conflict
);
    logic [COLOR_W-1:0] cv;
    logic [N_VERT-1:0]  hit;

    assign cv = coloring[int'(v)*COLOR_W +: COLOR_W];

    // Only the strictly-lower triangle of row v counts; self-loops and u>v are ignored.
    for (genvar u = 0; u < N_VERT; u++) begin : g_u
        assign hit[u] = (u < int'(v)) && adj[int'(v)*N_VERT + u] &&
                        (coloring[u*COLOR_W +: COLOR_W] == cv);
    end

    assign conflict = |hit;
endmodule

// File: rtl/graph_coloring_solver.sv
// Depth-first backtracking colour search over a latched adjacency matrix;
// returns the first proper colouring in vertex order, or found=0.
module graph_coloring_solver
    import gc_pkg::*;
#(
    parameter int N_VERT  = GC_N_VERT,
    parameter int COLOR_W = GC_COLOR_W,
    parameter int STEP_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    input  logic [N_VERT*N_VERT-1:0]  adj,
    input  logic [COLOR_W:0]          num_colors,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      found,
    output logic [N_VERT*COLOR_W-1:0] coloring,
    output logic [STEP_W-1:0]         steps
);
    localparam int VW = $clog2(N_VERT);
    localparam logic [VW-1:0] V_LAST = VW'(N_VERT-1);

    state_t                          state, nxt;
    logic [VW-1:0]                   v;
    logic [N_VERT-1:0][COLOR_W-1:0]  col;
    logic [N_VERT*N_VERT-1:0]        adj_q;
    logic [COLOR_W:0]                nc_q;
    logic [COLOR_W-1:0]              cur;
    logic                            conflict, accept, can_inc;

    assign accept   = (state == IDLE) && start && !res_valid;
    assign cur      = col[v];
    // One extra bit so a full budget of 2^COLOR_W colours is representable.
    assign can_inc  = ({1'b0, cur} < (nc_q - 1'b1));
    assign coloring = col;

    gc_conflict_check #(.N_VERT(N_VERT), .COLOR_W(COLOR_W), .VW(VW)) u_chk (
        .v       (v),
        .coloring(col),
        .adj     (adj_q),
        .conflict(conflict)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (accept) nxt = (num_colors == '0) ? DONE : CHECK;
            CHECK: if (conflict) nxt = NEXT;
                   else if (v == V_LAST) nxt = DONE;
            NEXT:  if (can_inc) nxt = CHECK;
                   else if (v == '0) nxt = DONE;
            DONE:  if (res_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            res_valid <= 1'b0;
            found     <= 1'b0;
            col       <= '0;
            steps     <= '0;
            adj_q     <= '0;
            nc_q      <= '0;
            v         <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    adj_q     <= adj;
                    nc_q      <= num_colors;
                    col       <= '0;
                    steps     <= '0;
                    v         <= '0;
                    found     <= 1'b0;
                    busy      <= 1'b1;
                    res_valid <= (num_colors == '0);
                end
                CHECK: begin
                    if (steps != '1) steps <= steps + 1'b1;
                    if (!conflict) begin
                        if (v == V_LAST) begin
                            found     <= 1'b1;
                            res_valid <= 1'b1;
                        end else begin
                            v              <= v + 1'b1;
                            col[v + 1'b1]  <= '0;
                        end
                    end
                end
                NEXT: begin
                    if (can_inc) begin
                        col[v] <= cur + 1'b1;
                    end else if (v != '0) begin
                        col[v] <= '0;
                        v      <= v - 1'b1;
                    end else begin
                        // Search space exhausted: publish an all-zero colouring.
                        col       <= '0;
                        found     <= 1'b0;
                        res_valid <= 1'b1;
                    end
                end
                DONE: if (res_ready) begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
